// File: rtl/img_scale_copier.sv
// ROM-to-framebuffer copier with run-time zoom / decimate / block-average / copy modes.
// Optional block averaging is compiled in when SCALER_AVG_EN is defined; otherwise mode 10 decimates.
module img_scale_copier #(
    parameter int unsigned SRC_W  = 160,
    parameter int unsigned SRC_H  = 120,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned MAX_F  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [2:0]        factor,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic [9:0]        dst_w,
    output logic [9:0]        dst_h,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DIM_W = 10;
    localparam int unsigned ACC_W = PIX_W + 4;
    localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_COPY, S_FLUSH, S_DONE} state_t;

    state_t            state;
    logic [2:0]        col_per, row_per, blk_f;
    logic [ADDR_W-1:0] col_step, row_step;
    logic [DIM_W-1:0]  dx, dy;
    logic [2:0]        col_sub, row_sub, bx, by;
    logic [ADDR_W-1:0] pix_base, row_base, blk_base, wr_next;
    logic              t_v, t_last, flush_wait;

    // floor(src/f) with constant numerators only, so no divider is built
    function automatic logic [DIM_W-1:0] div_dim(input int unsigned src, input logic [2:0] f);
        case (f)
            3'd2:    return DIM_W'(src / 2);
            3'd3:    return DIM_W'(src / 3);
            3'd4:    return DIM_W'(src / 4);
            3'd5:    return DIM_W'(src / 5);
            3'd6:    return DIM_W'(src / 6);
            3'd7:    return DIM_W'(src / 7);
            default: return DIM_W'(src);
        endcase
    endfunction

    // Per-run parameters decoded from mode/factor at the start request
    logic [2:0]        f_eff, f_sel, n_col_per, n_row_per, n_blk;
    logic [ADDR_W-1:0] n_col_step, n_row_step;
    logic [DIM_W-1:0]  n_dw, n_dh;
    logic              is_zoom, is_copy, is_avg;
`ifdef SCALER_AVG_EN
    logic [2:0]        shift, n_shift;
    logic              t_first;
    logic [ACC_W-1:0]  acc, acc_sum;
`endif

    always_comb begin
        f_eff      = factor;
        if (factor == 3'd0)
            f_eff = 3'd1;
        else if (32'(factor) > MAX_F)
            f_eff = 3'(MAX_F);
        is_zoom    = (mode == 2'b00);
        is_copy    = (mode == 2'b11);
        is_avg     = 1'b0;
`ifdef SCALER_AVG_EN
        is_avg     = (mode == 2'b10);
        n_shift    = 3'd0;
`endif
        f_sel      = f_eff;
        if (is_avg)
            f_sel = (f_eff == 3'd1) ? 3'd1 : (f_eff < 3'd4) ? 3'd2 : 3'd4;
        n_dw       = DIM_W'(SRC_W);
        n_dh       = DIM_W'(SRC_H);
        n_col_per  = 3'd1;
        n_row_per  = 3'd1;
        n_blk      = 3'd1;
        n_col_step = ADDR_W'(1);
        n_row_step = SRC_W_A;
        if (is_zoom) begin
            n_dw      = DIM_W'(SRC_W * 32'(f_sel));
            n_dh      = DIM_W'(SRC_H * 32'(f_sel));
            n_col_per = f_sel;
            n_row_per = f_sel;
        end else if (!is_copy) begin
            n_dw       = div_dim(SRC_W, f_sel);
            n_dh       = div_dim(SRC_H, f_sel);
            n_col_step = ADDR_W'(f_sel);
            n_row_step = ADDR_W'(f_sel) * SRC_W_A;
            if (is_avg) begin
                n_blk = f_sel;
`ifdef SCALER_AVG_EN
                n_shift = (f_sel == 3'd1) ? 3'd0 : (f_sel == 3'd2) ? 3'd2 : 3'd4;
`endif
            end
        end
    end

    logic issuing, blk_end, row_end, issue_last;
    logic [ADDR_W-1:0] pix_next, row_next, blk_next;

    always_comb begin
        issuing    = (state == S_SETUP) || (state == S_COPY);
        blk_end    = (bx == blk_f - 3'd1) && (by == blk_f - 3'd1);
        row_end    = (dx == dst_w - 10'd1);
        issue_last = issuing && blk_end && row_end && (dy == dst_h - 10'd1);
        pix_next   = pix_base + col_step;
        row_next   = row_base + row_step;
        blk_next   = blk_base + SRC_W_A;
    end

`ifdef SCALER_AVG_EN
    assign acc_sum = (t_first ? ACC_W'(0) : acc) + ACC_W'(rom_data);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            col_per    <= 3'd1;
            row_per    <= 3'd1;
            blk_f      <= 3'd1;
            col_step   <= ADDR_W'(1);
            row_step   <= SRC_W_A;
            dx         <= '0;
            dy         <= '0;
            col_sub    <= '0;
            row_sub    <= '0;
            bx         <= '0;
            by         <= '0;
            pix_base   <= '0;
            row_base   <= '0;
            blk_base   <= '0;
            wr_next    <= '0;
            t_v        <= 1'b0;
            t_last     <= 1'b0;
            flush_wait <= 1'b0;
            rom_addr   <= '0;
            ram_wraddr <= '0;
            ram_data   <= '0;
            ram_wren   <= 1'b0;
            dst_w      <= DIM_W'(SRC_W);
            dst_h      <= DIM_W'(SRC_H);
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SCALER_AVG_EN
            shift      <= '0;
            t_first    <= 1'b0;
            acc        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SETUP;
                        busy     <= 1'b1;
                        col_per  <= n_col_per;
                        row_per  <= n_row_per;
                        blk_f    <= n_blk;
                        col_step <= n_col_step;
                        row_step <= n_row_step;
                        dst_w    <= n_dw;
                        dst_h    <= n_dh;
                        dx       <= '0;
                        dy       <= '0;
                        col_sub  <= '0;
                        row_sub  <= '0;
                        bx       <= '0;
                        by       <= '0;
                        pix_base <= '0;
                        row_base <= '0;
                        blk_base <= '0;
                        rom_addr <= '0;
                        wr_next  <= '0;
`ifdef SCALER_AVG_EN
                        shift    <= n_shift;
`endif
                    end
                end
                S_SETUP, S_COPY: begin
                    // Walk the block, then the destination pixel grid, one read per cycle
                    if (!blk_end) begin
                        if (bx != blk_f - 3'd1) begin
                            bx       <= bx + 3'd1;
                            rom_addr <= rom_addr + ADDR_W'(1);
                        end else begin
                            bx       <= '0;
                            by       <= by + 3'd1;
                            blk_base <= blk_next;
                            rom_addr <= blk_next;
                        end
                    end else begin
                        bx <= '0;
                        by <= '0;
                        if (!row_end) begin
                            dx <= dx + 10'd1;
                            if (col_sub == col_per - 3'd1) begin
                                col_sub  <= '0;
                                pix_base <= pix_next;
                                blk_base <= pix_next;
                                rom_addr <= pix_next;
                            end else begin
                                col_sub  <= col_sub + 3'd1;
                                blk_base <= pix_base;
                                rom_addr <= pix_base;
                            end
                        end else begin
                            dx      <= '0;
                            dy      <= dy + 10'd1;
                            col_sub <= '0;
                            if (row_sub == row_per - 3'd1) begin
                                row_sub  <= '0;
                                row_base <= row_next;
                                pix_base <= row_next;
                                blk_base <= row_next;
                                rom_addr <= row_next;
                            end else begin
                                row_sub  <= row_sub + 3'd1;
                                pix_base <= row_base;
                                blk_base <= row_base;
                                rom_addr <= row_base;
                            end
                        end
                    end
                    if (issue_last) begin
                        state      <= S_FLUSH;
                        flush_wait <= 1'b0;
                    end else begin
                        state <= S_COPY;
                    end
                end
                S_FLUSH: begin
                    // Two cycles: ROM return, then the final write
                    if (flush_wait) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        flush_wait <= 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Read tags follow the ROM latency; the write lands one cycle after data returns
            t_v      <= issuing;
            t_last   <= blk_end;
            ram_wren <= t_v && t_last;
            if (t_v && t_last) begin
                ram_wraddr <= wr_next;
                wr_next    <= wr_next + ADDR_W'(1);
`ifdef SCALER_AVG_EN
                ram_data   <= PIX_W'(acc_sum >> shift);
`else
                ram_data   <= rom_data;
`endif
            end
`ifdef SCALER_AVG_EN
            t_first <= (bx == 3'd0) && (by == 3'd0);
            if (t_v)
                acc <= acc_sum;
`endif
        end
    end

endmodule

// File: tb/tb_img_scale_copier.sv
// Scoreboard bench for img_scale_copier: a pixel-level reference model queues expected writes,
// a negedge monitor pops and compares address, data and write cycle.
module tb_img_scale_copier;

    localparam int W    = 32;
    localparam int H    = 24;
    localparam int MAXF = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [2:0]  factor = 3'd1;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data = 8'd0;
    logic [18:0] ram_wraddr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [9:0]  dst_w, dst_h;
    logic        busy, done;

    img_scale_copier #(.SRC_W(W), .SRC_H(H), .PIX_W(8), .ADDR_W(19), .MAX_F(MAXF)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .factor(factor),
        .rom_addr(rom_addr), .rom_data(rom_data), .ram_wraddr(ram_wraddr),
        .ram_data(ram_data), .ram_wren(ram_wren), .dst_w(dst_w), .dst_h(dst_h),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    int   rom [W*H];
    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   idx;
    int   done_cnt = 0;
    int   done_idx = -1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rom_data <= (int'(rom_addr) < W*H) ? 8'(rom[int'(rom_addr)]) : 8'hEE;
    end

    // Monitor: every framebuffer write must match the head of the expected queue
    always @(negedge clk) begin
        idx = cyc - t0;
        if (ram_wren) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%0d cycle=%0d, expected no write",
                         ram_wraddr, ram_data, idx);
            end else begin
                e = q.pop_front();
                if (int'(ram_wraddr) != e.addr || int'(ram_data) != e.data || idx != e.cyc) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%0d cycle=%0d, expected addr=%0d data=%0d cycle=%0d",
                             ram_wraddr, ram_data, idx, e.addr, e.data, e.cyc);
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_idx = idx;
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // One copy run: model, start pulse, optional stray start / reset, completion checks
    task automatic run(input logic [1:0] m, input logic [2:0] fac, input int extra_at, input int reset_at);
        int  f, dw, dh, b, n, sh, v, j, i;
        bit  avg;
        f = (fac == 0) ? 1 : ((int'(fac) > MAXF) ? MAXF : int'(fac));
        avg = 1'b0;
`ifdef SCALER_AVG_EN
        avg = (m == 2'b10);
`endif
        if (avg) f = (f == 1) ? 1 : ((f < 4) ? 2 : 4);
        case (m)
            2'b00:   begin dw = W * f; dh = H * f; end
            2'b11:   begin dw = W;     dh = H;     end
            default: begin dw = W / f; dh = H / f; end
        endcase
        b = avg ? f * f : 1;
        n = dw * dh;
        sh = 0;
        for (int k = f; k > 1; k = k / 2) sh += 2;
        q.delete();
        for (int y = 0; y < dh; y++) begin
            for (int x = 0; x < dw; x++) begin
                if (m == 2'b00)      v = rom[(y / f) * W + x / f];
                else if (m == 2'b11) v = rom[y * W + x];
                else if (avg) begin
                    v = 0;
                    for (int by = 0; by < f; by++)
                        for (int bx = 0; bx < f; bx++)
                            v += rom[(y * f + by) * W + x * f + bx];
                    v = v >> sh;
                end else             v = rom[(y * f) * W + x * f];
                j = y * dw + x;
                q.push_back('{addr: j, data: v, cyc: j * b + b + 2});
            end
        end

        @(negedge clk);
        mode = m; factor = fac; start = 1'b1; done_cnt = 0; done_idx = -1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc - 1;
        chk("busy_at_setup", int'(busy), 1);
        chk("dst_w", int'(dst_w), dw);
        chk("dst_h", int'(dst_h), dh);

        i = 0;
        while (done_cnt == 0 && i < n * b + 40) begin
            @(negedge clk);
            #1;
            i++;
            start = ((cyc - t0) == extra_at);
            if ((cyc - t0) == reset_at) begin
                reset_n = 1'b0;
                #1;
                chk("abort_wren", int'(ram_wren), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_wraddr", int'(ram_wraddr), 0);
                q.delete();
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
        end
        start = 1'b0;
        chk("done_seen", done_cnt, 1);
        chk("done_cycle", done_idx, n * b + 3);
        chk("busy_at_done", int'(busy), 0);
        repeat (4) @(negedge clk);
        #1;
        chk("single_done", done_cnt, 1);
        chk("writes_left", q.size(), 0);
        chk("busy_idle", int'(busy), 0);
        q.delete();
    endtask

    initial begin
        for (int k = 0; k < W * H; k++) rom[k] = $urandom_range(0, 255);
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_wraddr", int'(ram_wraddr), 0);
        chk("rst_data", int'(ram_data), 0);
        chk("rst_wren", int'(ram_wren), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dst_w", int'(dst_w), W);
        chk("rst_dst_h", int'(dst_h), H);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run(2'b00, 3'd2, -1, -1);   // zoom x2
        run(2'b01, 3'd3, -1, -1);   // decimate /3, trailing rows/cols skipped
        run(2'b10, 3'd2, -1, -1);   // average (or decimate when averaging is absent)
        run(2'b10, 3'd3, -1, -1);   // average with F=3 folded to 2
        run(2'b11, 3'd0, 500, -1);  // plain copy, factor 0, stray start mid-run
        run(2'b00, 3'd4, -1, 1000); // zoom aborted by reset
        run(2'b00, 3'd3, -1, -1);   // restart after abort begins at address 0
        for (int r = 0; r < 4; r++)
            run(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/img_scale_copier.md
# img_scale_copier

Parametrised ROM→framebuffer copier that rescales a stored source image into the dual-port framebuffer RAM before display. It sits between the image ROM and the framebuffer write port, in the VGA pixel-clock domain. It replaces the fixed ×2 / ÷2 copier with run-time integer factors, four modes and a start/busy/done handshake. It reports the resulting destination dimensions to the display-window logic.

## Interface
- SRC_W, 160, source image width in pixels
- SRC_H, 120, source image height in pixels
- PIX_W, 8, pixel width in bits
- ADDR_W, 19, ROM and RAM address width
- MAX_F, 4, maximum scale factor (≥1)

- clk  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request, sampled only in IDLE
- mode  in  2  00 zoom (nearest), 01 decimate, 10 block average, 11 plain copy
- factor  in  3  scale factor; 0 is treated as 1, values >MAX_F clamp to MAX_F
- rom_addr  out  ADDR_W  source read address; synchronous ROM, 1-cycle latency
- rom_data  in  PIX_W  source pixel
- ram_wraddr  out  ADDR_W  framebuffer write address
- ram_data  out  PIX_W  framebuffer write data
- ram_wren  out  1  framebuffer write strobe
- dst_w  out  10  destination width, registered at start
- dst_h  out  10  destination height, registered at start
- busy  out  1  high from SETUP until the done pulse
- done  out  1  one-cycle pulse after the last write

## Operation
- States: IDLE → SETUP → COPY → FLUSH → DONE → IDLE.
- IDLE:
  - start=1 latches mode and effective factor F; go to SETUP.
  - start is ignored in every other state.
- SETUP:
  - Zoom: dst = SRC×F.
  - Decimate and average: dst = floor(SRC/F).
  - Copy: dst = SRC.
  - Clear the dst counters (dx, dy), the sub-pixel counters and the write address.
- COPY, zoom:
  - Each dst pixel (dx,dy) reads src(⌊dx/F⌋, ⌊dy/F⌋).
  - Use sub-counters, not dividers.
  - Source row is re-read F times.
- COPY, decimate:
  - Each dst pixel reads src(dx·F, dy·F).
  - Trailing source rows and columns beyond dst·F are skipped.
- COPY, average:
  - Each dst pixel reads the F×F source block row-major, one read per cycle.
  - Accumulate in a PIX_W+4-bit accumulator.
  - Write acc >> (2·log2 F).
  - F is restricted to {1,2,4}; an effective F of 3 is treated as 2.
- COPY, copy: linear read address 0…SRC_W·SRC_H−1.
- ram_wraddr increments by 1 per write, starting at 0, row-major with stride dst_w.
- FLUSH covers ROM latency: the last issued read is written, then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- dst_w and dst_h hold their value until the next start.

## Timing
- Reset values:
  - state IDLE.
  - rom_addr, ram_wraddr and ram_data = 0.
  - ram_wren, busy and done = 0.
  - dst_w = SRC_W and dst_h = SRC_H.
- Cycle 0: start sampled. Cycle 1: SETUP, busy=1. Cycle 2: first rom_addr. Cycle 3: first ram_wren.
- Zoom, decimate and copy write one pixel per cycle with no gaps. With N = dst_w·dst_h:
  - last write on cycle N+2.
  - done pulse on cycle N+3, busy falls the same cycle.
- Average issues F² reads per dst pixel.
  - Each write occurs 1 cycle after the block's last read.
  - Writes are therefore spaced F² cycles apart.
- ram_data and ram_wraddr are valid only while ram_wren=1; otherwise they hold their last value.
- reset_n low mid-copy aborts immediately to IDLE with reset values and no done pulse. The partially written framebuffer is left as is.
- start held high across DONE is not re-sampled until the cycle after returning to IDLE.

## Configuration
- SCALER_AVG_EN defined: block-average mode, accumulator and shifter are compiled in.
- SCALER_AVG_EN undefined: no accumulator; mode 10 behaves exactly as decimate (01).

## Test plan
- Zoom, F=2, defaults, rom[i]=i[7:0]:
  - dst 320×240, 76800 writes.
  - ram[0]=rom[0], ram[1]=rom[0], ram[2]=rom[1], ram[320]=rom[0], ram[640]=rom[160].
  - done on cycle 76803.
- Decimate, F=3:
  - dst 53×40, 2120 contiguous writes.
  - ram[1]=rom[3], ram[53]=rom[480].
  - done on cycle 2123.
- Average, F=2, SCALER_AVG_EN defined:
  - ram[0]=(rom[0]+rom[1]+rom[160]+rom[161])>>2.
  - writes 4 cycles apart, 4800 total.
- Average, F=2, SCALER_AVG_EN undefined: identical output to the decimate F=2 run (4800 writes, ram[1]=rom[2]).
- Copy, factor=0:
  - dst 160×120.
  - a second start pulsed at cycle 500 is ignored: exactly 19200 writes, one done.
- reset_n asserted at cycle 1000 of a zoom run:
  - ram_wren, busy and done are 0 immediately.
  - a new start afterwards restarts at ram_wraddr=0.
